// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM/WB payload and regfile/CC write-port bundle for the LC-3b write-back stage

typedef struct packed {
    logic       load_regfile;
    logic       load_cc;
    logic [1:0] wbmux_sel;
} lc3b_control_word;

interface writeback_stage_if;
    // mem stage -> write-back
    logic             stall_in;
    logic             valid_in;
    logic [15:0]      npc_in;
    logic [15:0]      ir_in;
    lc3b_control_word cw_in;
    logic [2:0]       dr_in;
    logic [15:0]      alu_in;
    logic [15:0]      mem_data_in;
    logic [15:0]      mar_in;

    // write-back -> decode / hazard unit
    logic             ld_reg_store;
    logic [15:0]      reg_data;
    logic [2:0]       dest_reg;
    logic             ld_cc_store;
    logic [2:0]       cc_data;
    logic             wb_valid;

    modport master (
        output stall_in, valid_in, npc_in, ir_in, cw_in, dr_in, alu_in, mem_data_in, mar_in,
        input  ld_reg_store, reg_data, dest_reg, ld_cc_store, cc_data, wb_valid
    );

    modport slave (
        input  stall_in, valid_in, npc_in, ir_in, cw_in, dr_in, alu_in, mem_data_in, mar_in,
        output ld_reg_store, reg_data, dest_reg, ld_cc_store, cc_data, wb_valid
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - LC-3b write-back stage; WB_RETIRE_CNT_EN adds a CNT_W-bit retire counter

module writeback_stage
`ifdef WB_RETIRE_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    writeback_stage_if.slave  wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  retire_cnt
`endif
);

    logic             valid_q,    valid_d;
    logic [15:0]      npc_q,      npc_d;
    logic [15:0]      ir_q,       ir_d;
    lc3b_control_word cw_q,       cw_d;
    logic [2:0]       dr_q,       dr_d;
    logic [15:0]      alu_q,      alu_d;
    logic [15:0]      mem_data_q, mem_data_d;
    logic [15:0]      mar_q,      mar_d;

    logic [7:0]       byte_sel;
    logic [15:0]      wb_data;

    always_comb begin
        valid_d    = valid_q;
        npc_d      = npc_q;
        ir_d       = ir_q;
        cw_d       = cw_q;
        dr_d       = dr_q;
        alu_d      = alu_q;
        mem_data_d = mem_data_q;
        mar_d      = mar_q;
        if (!wb.stall_in) begin
            valid_d    = wb.valid_in;
            npc_d      = wb.npc_in;
            ir_d       = wb.ir_in;
            cw_d       = wb.cw_in;
            dr_d       = wb.dr_in;
            alu_d      = wb.alu_in;
            mem_data_d = wb.mem_data_in;
            mar_d      = wb.mar_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            npc_q      <= '0;
            ir_q       <= '0;
            cw_q       <= '0;
            dr_q       <= '0;
            alu_q      <= '0;
            mem_data_q <= '0;
            mar_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            npc_q      <= npc_d;
            ir_q       <= ir_d;
            cw_q       <= cw_d;
            dr_q       <= dr_d;
            alu_q      <= alu_d;
            mem_data_q <= mem_data_d;
            mar_q      <= mar_d;
        end
    end

    // Byte loads pick the high byte on odd addresses, then sign-extend
    assign byte_sel = mar_q[0] ? mem_data_q[15:8] : mem_data_q[7:0];

    always_comb begin
        wb_data = alu_q;
        unique case (cw_q.wbmux_sel)
            2'b00: wb_data = alu_q;
            2'b01: wb_data = mem_data_q;
            2'b10: wb_data = npc_q;
            2'b11: wb_data = {{8{byte_sel[7]}}, byte_sel};
        endcase
    end

    always_comb begin
        wb.cc_data = 3'b001;
        if (wb_data[15]) begin
            wb.cc_data = 3'b100;
        end else if (wb_data == 16'h0000) begin
            wb.cc_data = 3'b010;
        end
    end

    assign wb.reg_data     = wb_data;
    assign wb.dest_reg     = dr_q;
    assign wb.ld_reg_store = valid_q & cw_q.load_regfile;
    assign wb.ld_cc_store  = valid_q & cw_q.load_cc;
    assign wb.wb_valid     = valid_q;

    // The instruction word and upper address bits travel with the payload but nothing here consumes them
    logic unused_payload;
    assign unused_payload = ^{ir_q, mar_q[15:1]};

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && !wb.stall_in) begin
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed table-driven bench for writeback_stage

module tb_writeback_stage;

    logic clk;
    logic rst_n;

    writeback_stage_if wbif();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    writeback_stage #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb         (wbif),
        .retire_cnt (retire_cnt)
    );
`else
    writeback_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wbif)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic        model_valid = 1'b0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        logic        valid;
        logic        lr;
        logic        lc;
        logic [1:0]  sel;
        logic [15:0] npc;
        logic [2:0]  dr;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [15:0] mar;
        logic        e_ld_reg;
        logic [15:0] e_data;
        logic [2:0]  e_dest;
        logic        e_ld_cc;
        logic [2:0]  e_cc;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic valid, input logic lr, input logic lc,
                         input logic [1:0] sel, input logic [15:0] npc, input logic [2:0] dr,
                         input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] mar);
        wbif.stall_in          = stall;
        wbif.valid_in          = valid;
        wbif.cw_in.load_regfile = lr;
        wbif.cw_in.load_cc     = lc;
        wbif.cw_in.wbmux_sel   = sel;
        wbif.npc_in            = npc;
        wbif.ir_in             = 16'h1234;
        wbif.dr_in             = dr;
        wbif.alu_in            = alu;
        wbif.mem_data_in       = mem;
        wbif.mar_in            = mar;
    endtask

    // One clock edge; the model tracks what valid_q and the retire count should become
    task automatic tick();
        @(posedge clk);
        if (model_valid && !wbif.stall_in) exp_cnt++;
        if (!wbif.stall_in) model_valid = wbif.valid_in;
        #1;
    endtask

    task automatic check_out(input string name, input logic ld_reg, input logic [15:0] data,
                             input logic [2:0] dest, input logic ld_cc, input logic [2:0] cc,
                             input logic valid);
        check({name, ".ld_reg_store"}, 32'(wbif.ld_reg_store), 32'(ld_reg));
        check({name, ".reg_data"},     32'(wbif.reg_data),     32'(data));
        check({name, ".dest_reg"},     32'(wbif.dest_reg),     32'(dest));
        check({name, ".ld_cc_store"},  32'(wbif.ld_cc_store),  32'(ld_cc));
        check({name, ".cc_data"},      32'(wbif.cc_data),      32'(cc));
        check({name, ".wb_valid"},     32'(wbif.wb_valid),     32'(valid));
`ifdef WB_RETIRE_CNT_EN
        check({name, ".retire_cnt"},   retire_cnt,             exp_cnt);
`endif
    endtask

    initial begin
        //          v    lr   lc   sel    npc       dr    alu       mem       mar       ldr  data      dest  ldc  cc
        vecs[0] = '{1'b1,1'b1,1'b1,2'b00,16'h0000,3'd3,16'h8001,16'h0000,16'h0000, 1'b1,16'h8001,3'd3,1'b1,3'b100};
        vecs[1] = '{1'b1,1'b1,1'b1,2'b11,16'h0000,3'd2,16'h0000,16'h7F80,16'h1234, 1'b1,16'hFF80,3'd2,1'b1,3'b100};
        vecs[2] = '{1'b1,1'b1,1'b1,2'b11,16'h0000,3'd2,16'h0000,16'h7F80,16'h1235, 1'b1,16'h007F,3'd2,1'b1,3'b001};
        vecs[3] = '{1'b1,1'b1,1'b0,2'b10,16'h3002,3'd7,16'hAAAA,16'h5555,16'h0000, 1'b1,16'h3002,3'd7,1'b0,3'b001};
        vecs[4] = '{1'b1,1'b1,1'b1,2'b01,16'h1111,3'd5,16'h2222,16'h0000,16'h0001, 1'b1,16'h0000,3'd5,1'b1,3'b010};
        vecs[5] = '{1'b0,1'b1,1'b1,2'b00,16'h0000,3'd4,16'h1234,16'h0000,16'h0000, 1'b0,16'h1234,3'd4,1'b0,3'b001};
        vecs[6] = '{1'b1,1'b1,1'b1,2'b11,16'h0000,3'd6,16'h0000,16'h80FF,16'h0003, 1'b1,16'hFF80,3'd6,1'b1,3'b100};
        vecs[7] = '{1'b1,1'b1,1'b1,2'b01,16'h0000,3'd0,16'h0000,16'h7FFF,16'h0000, 1'b1,16'h7FFF,3'd0,1'b1,3'b001};
        vecs[8] = '{1'b1,1'b0,1'b1,2'b00,16'h0000,3'd1,16'hFFFF,16'h0000,16'h0000, 1'b0,16'hFFFF,3'd1,1'b1,3'b100};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 16'h0000, 3'd0, 1'b0, 3'b010, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(1'b0, vecs[i].valid, vecs[i].lr, vecs[i].lc, vecs[i].sel, vecs[i].npc,
                  vecs[i].dr, vecs[i].alu, vecs[i].mem, vecs[i].mar);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].e_ld_reg, vecs[i].e_data, vecs[i].e_dest,
                      vecs[i].e_ld_cc, vecs[i].e_cc, vecs[i].valid);
        end

        // Stall: ADD r1 <- 0 is held for three cycles while new inputs are presented
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0, 3'd1, 16'h0000, 16'h0, 16'h0);
        tick();
        check_out("stall_cap", 1'b1, 16'h0000, 3'd1, 1'b1, 3'b010, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0, 3'd6, 16'h5555, 16'h0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out($sformatf("stall_hold%0d", k), 1'b1, 16'h0000, 3'd1, 1'b1, 3'b010, 1'b1);
        end
        wbif.stall_in = 1'b0;
        tick();
        check_out("stall_rel", 1'b1, 16'h5555, 3'd6, 1'b1, 3'b001, 1'b1);

        // Reset asserted mid-stall with a valid instruction held
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0, 3'd2, 16'h0, 16'h8000, 16'h0);
        tick();
        #2;
        rst_n = 1'b0;
        model_valid = 1'b0;
        exp_cnt = 32'd0;
        #1;
        check_out("rst_mid", 1'b0, 16'h0000, 3'd0, 1'b0, 3'b010, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_out("rst_stall", 1'b0, 16'h0000, 3'd0, 1'b0, 3'b010, 1'b0);
        wbif.stall_in = 1'b0;
        tick();
        check_out("rst_after", 1'b1, 16'h8000, 3'd2, 1'b1, 3'b100, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 16'h0, 3'd3, 16'h0001, 16'h0, 16'h0);
        tick();
        check_out("bubble2", 1'b0, 16'h0001, 3'd3, 1'b0, 3'b001, 1'b0);
        tick();
        check_out("bubble3", 1'b0, 16'h0001, 3'd3, 1'b0, 3'b001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
